// File: rtl/decode_stage_pkg.sv
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Shared types, ALU/operand encodings and field decoders for the
//            RV32I/M registered decode stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

  localparam int C_XLEN = 32;

  // ALU operation codes (extends the original define.vh numbering)
  localparam logic [5:0] ALU_LUI    = 6'd0;
  localparam logic [5:0] ALU_JAL    = 6'd1;
  localparam logic [5:0] ALU_JALR   = 6'd2;
  localparam logic [5:0] ALU_BEQ    = 6'd3;
  localparam logic [5:0] ALU_BNE    = 6'd4;
  localparam logic [5:0] ALU_BLT    = 6'd5;
  localparam logic [5:0] ALU_BGE    = 6'd6;
  localparam logic [5:0] ALU_BLTU   = 6'd7;
  localparam logic [5:0] ALU_BGEU   = 6'd8;
  localparam logic [5:0] ALU_LB     = 6'd9;
  localparam logic [5:0] ALU_LH     = 6'd10;
  localparam logic [5:0] ALU_LW     = 6'd11;
  localparam logic [5:0] ALU_LBU    = 6'd12;
  localparam logic [5:0] ALU_LHU    = 6'd13;
  localparam logic [5:0] ALU_SB     = 6'd14;
  localparam logic [5:0] ALU_SH     = 6'd15;
  localparam logic [5:0] ALU_SW     = 6'd16;
  localparam logic [5:0] ALU_ADD    = 6'd17;
  localparam logic [5:0] ALU_SUB    = 6'd18;
  localparam logic [5:0] ALU_XOR    = 6'd19;
  localparam logic [5:0] ALU_OR     = 6'd20;
  localparam logic [5:0] ALU_AND    = 6'd21;
  localparam logic [5:0] ALU_SLT    = 6'd22;
  localparam logic [5:0] ALU_SLTU   = 6'd23;
  localparam logic [5:0] ALU_SLL    = 6'd24;
  localparam logic [5:0] ALU_SRL    = 6'd25;
  localparam logic [5:0] ALU_SRA    = 6'd26;
  localparam logic [5:0] ALU_MUL    = 6'd27;
  localparam logic [5:0] ALU_MULH   = 6'd28;
  localparam logic [5:0] ALU_MULHSU = 6'd29;
  localparam logic [5:0] ALU_MULHU  = 6'd30;
  localparam logic [5:0] ALU_DIV    = 6'd31;
  localparam logic [5:0] ALU_DIVU   = 6'd32;
  localparam logic [5:0] ALU_REM    = 6'd33;
  localparam logic [5:0] ALU_REMU   = 6'd34;
  localparam logic [5:0] ALU_NOP    = 6'd35;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  localparam logic [31:0] c_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_ebreak = 32'h0010_0073;

  typedef struct packed {
    logic [4:0]        srcreg1_num;
    logic [4:0]        srcreg2_num;
    logic [4:0]        dstreg_num;
    logic [C_XLEN-1:0] imm;
    logic [5:0]        alucode;
    logic [1:0]        aluop1_type;
    logic [1:0]        aluop2_type;
    logic              reg_we;
    logic              is_load;
    logic              is_store;
    logic              is_halt;
    logic              is_illegal;
  } decoded_t;

  typedef struct packed {
    logic [C_XLEN-1:0] pc;
    decoded_t          dec;
  } entry_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // alt selects SUB/SRA (funct7 = 0100000) over ADD/SRL
  function automatic logic [5:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [5:0] alu_mext(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  function automatic logic [5:0] alu_load(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_LB;
      3'b001:  return ALU_LH;
      3'b010:  return ALU_LW;
      3'b100:  return ALU_LBU;
      3'b101:  return ALU_LHU;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [5:0] alu_store(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_SB;
      3'b001:  return ALU_SH;
      3'b010:  return ALU_SW;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [5:0] alu_branch(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_BEQ;
      3'b001:  return ALU_BNE;
      3'b100:  return ALU_BLT;
      3'b101:  return ALU_BGE;
      3'b110:  return ALU_BLTU;
      3'b111:  return ALU_BGEU;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// ============================================================================
// Module   : decode_comb
// Brief    : Purely combinational RV32I/M instruction word -> decoded bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int ENABLE_M       = 1,
  parameter int HALT_ON_EBREAK = 0
) (
  input  logic [31:0] i_ir,
  output decoded_t    o_dec
);

  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;
  logic        w_illegal;
  decoded_t    w_dec;

  assign w_opcode = i_ir[6:0];
  assign w_rd     = i_ir[11:7];
  assign w_funct3 = i_ir[14:12];
  assign w_rs1    = i_ir[19:15];
  assign w_rs2    = i_ir[24:20];
  assign w_funct7 = i_ir[31:25];

  assign w_imm_i  = {{20{i_ir[31]}}, i_ir[31:20]};
  assign w_imm_s  = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
  assign w_imm_b  = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
  assign w_imm_u  = {i_ir[31:12], 12'b0};
  assign w_imm_j  = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_ir[24:20]};

  always_comb begin
    w_dec         = '0;
    w_dec.alucode = ALU_NOP;
    w_illegal     = 1'b0;
    case (w_opcode)
      c_opc_op: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.srcreg2_num = w_rs2;
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_REG;
        w_dec.reg_we      = 1'b1;
        if (w_funct7 == 7'b0000000)
          w_dec.alucode = alu_base(w_funct3, 1'b0);
        else if (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))
          w_dec.alucode = alu_base(w_funct3, 1'b1);
        else if (w_funct7 == 7'b0000001 && ENABLE_M != 0)
          w_dec.alucode = alu_mext(w_funct3);
        else
          w_illegal = 1'b1;
      end
      c_opc_opimm: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.imm         = w_imm_i;
        w_dec.alucode     = alu_base(w_funct3, 1'b0);
        // shift-immediates carry funct7 in the upper immediate bits
        if (w_funct3 == 3'b001) begin
          w_dec.imm = w_imm_sh;
          if (w_funct7 != 7'b0000000) w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          w_dec.imm = w_imm_sh;
          if (w_funct7 == 7'b0100000)      w_dec.alucode = alu_base(w_funct3, 1'b1);
          else if (w_funct7 != 7'b0000000) w_illegal = 1'b1;
        end
      end
      c_opc_load: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.is_load     = 1'b1;
        w_dec.imm         = w_imm_i;
        w_dec.alucode     = alu_load(w_funct3);
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) w_illegal = 1'b1;
      end
      c_opc_store: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.srcreg2_num = w_rs2;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.is_store    = 1'b1;
        w_dec.imm         = w_imm_s;
        w_dec.alucode     = alu_store(w_funct3);
        if (w_funct3 > 3'b010) w_illegal = 1'b1;
      end
      c_opc_branch: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.srcreg2_num = w_rs2;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_REG;
        w_dec.imm         = w_imm_b;
        w_dec.alucode     = alu_branch(w_funct3);
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
      end
      c_opc_lui: begin
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.imm         = w_imm_u;
        w_dec.alucode     = ALU_LUI;
      end
      c_opc_auipc: begin
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_PC;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.imm         = w_imm_u;
        w_dec.alucode     = ALU_ADD;
      end
      c_opc_jal: begin
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_PC;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.imm         = w_imm_j;
        w_dec.alucode     = ALU_JAL;
      end
      c_opc_jalr: begin
        w_dec.srcreg1_num = w_rs1;
        w_dec.dstreg_num  = w_rd;
        w_dec.aluop1_type = OP_TYPE_REG;
        w_dec.aluop2_type = OP_TYPE_IMM;
        w_dec.reg_we      = 1'b1;
        w_dec.imm         = w_imm_i;
        w_dec.alucode     = ALU_JALR;
      end
      c_opc_system: begin
        if (i_ir == c_ecall)       w_dec.is_halt = 1'b1;
        else if (i_ir == c_ebreak) w_dec.is_halt = (HALT_ON_EBREAK != 0);
        else                       w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    // an illegal word must not have any architectural side effect downstream
    if (w_illegal) begin
      w_dec            = '0;
      w_dec.alucode    = ALU_NOP;
      w_dec.is_illegal = 1'b1;
    end
  end

  assign o_dec = w_dec;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I/M decode stage with 2-entry skid buffer, flush
//            and sticky halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ENABLE_M       = 1,
  parameter int HALT_ON_EBREAK = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      srcreg1_num,
  output logic [4:0]      srcreg2_num,
  output logic [4:0]      dstreg_num,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      alucode,
  output logic [1:0]      aluop1_type,
  output logic [1:0]      aluop2_type,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_halt,
  output logic            is_illegal,
  output logic            halted
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage: only XLEN=32 is supported");
  end

  decoded_t w_dec;
  entry_t   w_in_entry;

  state_t   r_state;
  logic     r_v0;
  logic     r_v1;
  entry_t   r_e0;
  entry_t   r_e1;
  logic     r_in_ready;

  state_t   w_state_nxt;
  logic     w_v0_nxt;
  logic     w_v1_nxt;
  entry_t   w_e0_nxt;
  entry_t   w_e1_nxt;
  logic     w_acc;
  logic     w_pop;

  decode_comb #(
    .ENABLE_M       (ENABLE_M),
    .HALT_ON_EBREAK (HALT_ON_EBREAK)
  ) u_decode_comb (
    .i_ir  (ir),
    .o_dec (w_dec)
  );

  assign w_in_entry.pc  = pc;
  assign w_in_entry.dec = w_dec;

  assign w_acc = in_valid && r_in_ready;
  assign w_pop = r_v0 && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_v0_nxt    = r_v0;
    w_v1_nxt    = r_v1;
    w_e0_nxt    = r_e0;
    w_e1_nxt    = r_e1;
    if (flush) begin
      w_v0_nxt = 1'b0;
      w_v1_nxt = 1'b0;
    end else begin
      if (w_acc && w_dec.is_halt) w_state_nxt = ST_HALT;
      // in_ready implies an empty skid entry, so accept and r_v1 never coincide
      if (w_pop) begin
        if (r_v1) begin
          w_e0_nxt = r_e1;
          w_v1_nxt = 1'b0;
        end else if (w_acc) begin
          w_e0_nxt = w_in_entry;
        end else begin
          w_v0_nxt = 1'b0;
        end
      end else if (w_acc) begin
        if (r_v0) begin
          w_e1_nxt = w_in_entry;
          w_v1_nxt = 1'b1;
        end else begin
          w_e0_nxt = w_in_entry;
          w_v0_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_e0       <= '0;
      r_e1       <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_v0       <= w_v0_nxt;
      r_v1       <= w_v1_nxt;
      r_e0       <= w_e0_nxt;
      r_e1       <= w_e1_nxt;
      r_in_ready <= (w_state_nxt == ST_RUN) && !w_v1_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_v0;
  assign halted      = (r_state == ST_HALT);
  assign pc_out      = r_e0.pc;
  assign srcreg1_num = r_e0.dec.srcreg1_num;
  assign srcreg2_num = r_e0.dec.srcreg2_num;
  assign dstreg_num  = r_e0.dec.dstreg_num;
  assign imm         = r_e0.dec.imm;
  assign alucode     = r_e0.dec.alucode;
  assign aluop1_type = r_e0.dec.aluop1_type;
  assign aluop2_type = r_e0.dec.aluop2_type;
  assign reg_we      = r_e0.dec.reg_we;
  assign is_load     = r_e0.dec.is_load;
  assign is_store    = r_e0.dec.is_store;
  assign is_halt     = r_e0.dec.is_halt;
  assign is_illegal  = r_e0.dec.is_illegal;

endmodule

`default_nettype wire
